spi_master_mode: RTL and testbench
==================================

Name: spi_master_mode

Overview:
- Parametrised SPI master; successor to the fixed 8-bit, Mode-0 SPI master.
- Adds:
  - configurable word width;
  - runtime CPOL/CPHA (all four SPI modes);
  - runtime clock divider;
  - multiple chip selects with a hold-between-words option.
- Sits on the IO bus behind a memory-mapped register wrapper (wrapper out of scope) and drives flash/SD/Ethernet-style peripherals.

Parameters:
- DATA_WIDTH, 8, bits per transfer word (2..32).
- DIV_WIDTH, 8, width of the clk_div input.
- NUM_CS, 1, number of active-low chip-select outputs (1..8).
- CS_SEL_WIDTH, 1, width of cs_sel; must satisfy 2^CS_SEL_WIDTH >= NUM_CS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset: reset=0 immediately clears all state.
- start  input  1  transfer request; sampled only when busy=0.
- data_in  input  DATA_WIDTH  word to transmit.
- cpol  input  1  clock polarity: SCLK idle level.
- cpha  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- clk_div  input  DIV_WIDTH  half-period of SCLK, equal to clk_div+1 system clocks.
- cs_sel  input  CS_SEL_WIDTH  index of the chip select to assert.
- cs_keep  input  1  keep CS asserted after this word completes.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse; data_out is valid in the same cycle.
- data_out  output  DATA_WIDTH  received word.
- spi_clk  output  1  SCLK.
- spi_mosi  output  1  MOSI.
- spi_miso  input  1  MISO.
- spi_cs_n  output  NUM_CS  chip selects, active low.

Behaviour:
- Reset values:
  - busy=0, done=0, data_out=0;
  - spi_clk=0, spi_mosi=0, spi_cs_n=all ones;
  - state IDLE; internal counters cleared.
- States: IDLE, TRANSFER, DONE.
- IDLE:
  - spi_clk is driven to the currently latched cpol (0 after reset).
  - start=1 in cycle T:
    - latch data_in, cpol, cpha, clk_div, cs_sel, cs_keep;
    - at T+1: busy=1, spi_cs_n[cs_sel]=0 and all other CS bits =1, spi_clk=cpol;
    - if cpha=0, spi_mosi=data_in MSB at T+1;
    - state→TRANSFER, divider counter=0, edge counter=2*DATA_WIDTH.
- TRANSFER:
  - The divider counter increments every cycle. When it equals the latched clk_div it wraps to 0, spi_clk toggles, and the edge counter decrements.
  - Edge 1 is visible at T+1+(clk_div+1). Edges alternate leading/trailing.
  - cpha=0: sample spi_miso into the shift register on each leading edge; drive the next MOSI bit on each trailing edge except the last.
  - cpha=1: drive a MOSI bit on each leading edge (MSB first); sample on each trailing edge.
  - MSB first, both directions.
  - After edge 2*DATA_WIDTH: state→DONE; spi_clk is back at cpol.
- DONE (single cycle):
  - done=1; data_out updated with the received word (it holds the previous value until then);
  - spi_cs_n released to all ones unless cs_keep was latched.
  - The next cycle: busy=0, state IDLE.
- Busy duration = 2*DATA_WIDTH*(clk_div+1)+1 cycles.
- start while busy=1 is ignored; the request is not queued.
- start held high continuously: a new transfer begins the cycle after busy falls (back-to-back words).
- Changes to cpol/cpha/clk_div/cs_sel during busy have no effect on the current word.
- cs_keep=1 words leave CS low in IDLE. The next start with a different cs_sel deasserts the old CS and asserts the new one at T+1.
- clk_div=0 is legal: SCLK = clk/2.
- clk_div all-ones is legal: no overflow, because the counter is DIV_WIDTH bits and is compared for equality.
- cs_sel >= NUM_CS: no CS asserted; the transfer still runs.
- Reset asserted mid-transfer: outputs return to reset values asynchronously; no done pulse; partial received data is discarded.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- Defined:
  - adds input lsb_first (1 bit), latched at start;
  - when 1, both TX and RX are LSB first (the first bit driven is data_in[0], and the first bit sampled lands in data_out[0]).
- Undefined: the port is absent; transfers are always MSB first.

Test Plan:
- Mode 0, DATA_WIDTH=8, clk_div=0, data_in=0xA5, MISO loopback from MOSI:
  - expect 16 SCLK edges;
  - busy high for exactly 17 cycles;
  - done pulse with data_out=0xA5;
  - CS low only while busy.
- Mode 3 (cpol=1, cpha=1), clk_div=3, data_in=0x3C, slave model returning 0xC3:
  - SCLK idles high; half-period is 4 cycles;
  - MOSI changes only on falling edges;
  - data_out=0xC3; busy high for 65 cycles.
- Modes 1 and 2, data_in=0x81, slave model returning 0x7E:
  - MISO sampled on the correct edge per mode;
  - data_out=0x7E in both modes.
- NUM_CS=4, two words: 0x11 with cs_sel=2 and cs_keep=1, then 0x22 with cs_sel=2 and cs_keep=0:
  - spi_cs_n=4'b1011 continuously across both words;
  - returns to 4'b1111 after the second done.
- Start pulsed while busy, and start held high for 3 words:
  - the mid-transfer pulse is ignored;
  - held start gives 3 contiguous transfers with exactly one idle cycle between them.
- Reset driven low at edge 7 of a transfer:
  - immediately spi_cs_n=all ones, busy=0, spi_clk=0;
  - no done pulse;
  - the next transfer completes correctly (and with SPI_MASTER_LSB_FIRST_EN, lsb_first=1 and data_in=0x01 puts the first MOSI bit at 1).

Source files
------------

// File: rtl/spi_master_mode_if.sv
// Bus bundle for spi_master_mode: host-side request/response plus SPI pins.
// With SPI_MASTER_LSB_FIRST_EN defined the bundle also carries lsb_first.
`default_nettype none

interface spi_master_mode_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8,
    parameter int NUM_CS       = 1,
    parameter int CS_SEL_WIDTH = 1
);
    logic                    start;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    cpol;
    logic                    cpha;
    logic [DIV_WIDTH-1:0]    clk_div;
    logic [CS_SEL_WIDTH-1:0] cs_sel;
    logic                    cs_keep;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    spi_clk;
    logic                    spi_mosi;
    logic                    spi_miso;
    logic [NUM_CS-1:0]       spi_cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic                    lsb_first;

    modport master (
        input  start, data_in, cpol, cpha, clk_div, cs_sel, cs_keep, spi_miso, lsb_first,
        output busy, done, data_out, spi_clk, spi_mosi, spi_cs_n
    );
    modport slave (
        output start, data_in, cpol, cpha, clk_div, cs_sel, cs_keep, spi_miso, lsb_first,
        input  busy, done, data_out, spi_clk, spi_mosi, spi_cs_n
    );
`else
    modport master (
        input  start, data_in, cpol, cpha, clk_div, cs_sel, cs_keep, spi_miso,
        output busy, done, data_out, spi_clk, spi_mosi, spi_cs_n
    );
    modport slave (
        output start, data_in, cpol, cpha, clk_div, cs_sel, cs_keep, spi_miso,
        input  busy, done, data_out, spi_clk, spi_mosi, spi_cs_n
    );
`endif
endinterface

`default_nettype wire

// File: rtl/spi_master_mode.sv
// spi_master_mode: SPI master, all four modes, runtime divider, multiple CS.
// Optional SPI_MASTER_LSB_FIRST_EN adds a per-word LSB-first bit order.
`default_nettype none

module spi_master_mode #(
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8,
    parameter int NUM_CS       = 1,
    parameter int CS_SEL_WIDTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_mode_if.master bus
);
    localparam int                ECW   = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [ECW-1:0]    EDGES = ECW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic [NUM_CS-1:0]       cs_n_q, cs_n_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic [ECW-1:0]          edge_cnt_q, edge_cnt_d;
    logic                    cpol_q, cpol_d;
    logic                    cpha_q, cpha_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic                    keep_q, keep_d;

    logic                    w_lsb_in;
    logic                    w_lsb;
    logic [NUM_CS-1:0]       w_cs_dec;
    logic                    w_leading;
    logic                    w_sample;
    logic                    w_drive;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign w_lsb_in = bus.lsb_first;
    assign w_lsb    = lsb_q;
`else
    assign w_lsb_in = 1'b0;
    assign w_lsb    = 1'b0;
`endif

    // An out-of-range select leaves every chip select deasserted.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (32'(bus.cs_sel) == i) w_cs_dec[i] = 1'b0;
        end
    end

    // Edge number k = EDGES - edge_cnt_q + 1 is odd (leading) when edge_cnt_q is even.
    assign w_leading = ~edge_cnt_q[0];
    assign w_sample  = cpha_q ? ~w_leading : w_leading;
    assign w_drive   = cpha_q ? w_leading : (~w_leading && (edge_cnt_q != ECW'(1)));

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        shreg_d    = shreg_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        keep_d     = keep_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif
        case (state_q)
            IDLE: begin
                sclk_d = cpol_q;
                if (bus.start) begin
                    cpol_d     = bus.cpol;
                    cpha_d     = bus.cpha;
                    div_d      = bus.clk_div;
                    keep_d     = bus.cs_keep;
`ifdef SPI_MASTER_LSB_FIRST_EN
                    lsb_d      = bus.lsb_first;
`endif
                    busy_d     = 1'b1;
                    cs_n_d     = w_cs_dec;
                    sclk_d     = bus.cpol;
                    shreg_d    = bus.data_in;
                    if (!bus.cpha)
                        mosi_d = w_lsb_in ? bus.data_in[0] : bus.data_in[DATA_WIDTH-1];
                    div_cnt_d  = '0;
                    edge_cnt_d = EDGES;
                    state_d    = TRANSFER;
                end
            end
            TRANSFER: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == div_q) begin
                    div_cnt_d  = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q - 1'b1;
                    if (w_drive)
                        mosi_d = w_lsb ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
                    if (w_sample)
                        shreg_d = w_lsb ? {bus.spi_miso, shreg_q[DATA_WIDTH-1:1]}
                                        : {shreg_q[DATA_WIDTH-2:0], bus.spi_miso};
                    if (edge_cnt_q == ECW'(1)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        data_out_d = shreg_d;
                        if (!keep_q) cs_n_d = '1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            shreg_q    <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            keep_q     <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            shreg_q    <= shreg_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            keep_q     <= keep_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_mode.sv
// Testbench for spi_master_mode: a bus-level slave model drives MISO and
// collects MOSI, and expectations come from word-level SPI rules.
`default_nettype none

module tb_spi_master_mode;
    localparam int W   = 8;
    localparam int DW  = 8;
    localparam int NCS = 4;
    localparam int SW  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_master_mode_if #(.DATA_WIDTH(W), .DIV_WIDTH(DW), .NUM_CS(NCS), .CS_SEL_WIDTH(SW)) bus ();

    spi_master_mode #(.DATA_WIDTH(W), .DIV_WIDTH(DW), .NUM_CS(NCS), .CS_SEL_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] cs_idle  = 4'hF;
    logic [7:0] last_out = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_cs(input logic [2:0] sel);
        return (sel < 3'd4) ? ~(4'b0001 << sel) : 4'hF;
    endfunction

    // Bit i in transmission order.
    function automatic logic nth(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    task automatic xfer(input logic [7:0] din, input logic [7:0] sword, input logic pol,
                        input logic pha, input logic [7:0] div, input logic [2:0] sel,
                        input logic keep, input logic lsb, input logic hold, input logic pulse_mid);
        int busy_cyc, edges, since, bad, guard, limit, idx;
        logic [7:0] rx;
        logic pclk, pmosi, got_done, drv, leading, l;
        bus.data_in = din; bus.cpol = pol; bus.cpha = pha;
        bus.clk_div = div; bus.cs_sel = sel; bus.cs_keep = keep;
`ifdef SPI_MASTER_LSB_FIRST_EN
        bus.lsb_first = lsb;
        l = lsb;
`else
        l = 1'b0;
`endif
        if (!pha) bus.spi_miso = nth(sword, 0, l);
        bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        check("busy_rise", bus.busy, 1);
        check("cs_assert", bus.spi_cs_n, exp_cs(sel));
        check("sclk_start", bus.spi_clk, pol);
        check("data_out_hold", bus.data_out, last_out);
        if (!pha) check("mosi_first", bus.spi_mosi, nth(din, 0, l));
        if (!hold) begin
            bus.cpol = ~pol; bus.cpha = ~pha;
            bus.clk_div = 8'($urandom); bus.cs_sel = 3'($urandom); bus.data_in = 8'($urandom);
        end
        rx = 8'h00; busy_cyc = 1; edges = 0; since = 0; bad = 0; guard = 0;
        pclk = pol; pmosi = bus.spi_mosi; got_done = 1'b0;
        limit = 16 * (int'(div) + 1) + 8;
        while (!got_done && guard < limit) begin
            @(posedge clk); #1;
            guard++; since++;
            if (pulse_mid) bus.start = (guard == 5);
            if (bus.busy) busy_cyc++;
            drv = 1'b0;
            if (bus.spi_clk !== pclk) begin
                edges++;
                if (since != int'(div) + 1) bad++;
                since = 0;
                leading = (edges % 2 == 1);
                idx = (edges - 1) / 2;
                if (leading != pha) rx[l ? idx : 7 - idx] = bus.spi_mosi;
                if (!pha && !leading && edges < 16) begin
                    bus.spi_miso = nth(sword, edges / 2, l); drv = 1'b1;
                end
                if (pha && leading) begin
                    bus.spi_miso = nth(sword, idx, l); drv = 1'b1;
                end
            end
            if (bus.spi_mosi !== pmosi && !drv) bad++;
            pclk = bus.spi_clk; pmosi = bus.spi_mosi;
            if (bus.done) got_done = 1'b1;
            else if (bus.spi_cs_n !== exp_cs(sel)) bad++;
        end
        check("done_seen", got_done, 1);
        check("data_out", bus.data_out, sword);
        check("mosi_word", rx, din);
        check("edge_count", edges, 16);
        check("busy_cycles", busy_cyc, 16 * (int'(div) + 1) + 1);
        check("edge_timing", bad, 0);
        cs_idle = keep ? exp_cs(sel) : 4'hF;
        check("cs_done", bus.spi_cs_n, cs_idle);
        last_out = sword;
        @(posedge clk); #1;
        check("busy_fall", bus.busy, 0);
        check("done_pulse", bus.done, 0);
        check("sclk_idle", bus.spi_clk, pol);
        check("cs_idle", bus.spi_cs_n, cs_idle);
        if (pulse_mid) begin
            @(posedge clk); #1;
            check("no_queue", bus.busy, 0);
        end
    endtask

    initial begin
        int edges, guard;
        logic pclk;
        bus.start = 1'b0; bus.data_in = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.clk_div = '0; bus.cs_sel = '0; bus.cs_keep = 1'b0; bus.spi_miso = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_sclk", bus.spi_clk, 0);
        check("rst_mosi", bus.spi_mosi, 0);
        check("rst_cs", bus.spi_cs_n, 4'hF);
        reset = 1'b1;
        @(posedge clk); #1;

        xfer(8'hA5, 8'hA5, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h3C, 8'hC3, 1'b1, 1'b1, 8'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h81, 8'h7E, 1'b0, 1'b1, 8'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h81, 8'h7E, 1'b1, 1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h11, 8'($urandom), 1'b0, 1'b0, 8'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(8'h22, 8'($urandom), 1'b0, 1'b0, 8'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'($urandom), 8'($urandom), 1'b0, 1'b1, 8'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            xfer(8'($urandom), 8'($urandom), 1'b1, 1'b0, 8'd0, 3'd3, 1'b0, 1'b0, (i < 2), 1'b0);
        xfer(8'h5A, 8'h96, 1'b0, 1'b0, 8'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hC7, 8'h18, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom_range(0, 4)), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);

        // Abort a word with reset at its seventh SCLK edge.
        bus.data_in = 8'h6B; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd1;
        bus.cs_sel = 3'd1; bus.cs_keep = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 0; guard = 0; pclk = bus.spi_clk;
        while (edges < 7 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            if (bus.spi_clk !== pclk) edges++;
            pclk = bus.spi_clk;
        end
        check("abort_edge7", edges, 7);
        reset = 1'b0;
        #1;
        check("abort_cs", bus.spi_cs_n, 4'hF);
        check("abort_busy", bus.busy, 0);
        check("abort_sclk", bus.spi_clk, 0);
        check("abort_done", bus.done, 0);
        @(posedge clk); #1;
        check("abort_no_done", bus.done, 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("abort_data_out", bus.data_out, 0);
        cs_idle = 4'hF; last_out = 8'h00;
        xfer(8'h01, 8'hB4, 1'b0, 1'b0, 8'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
